spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Command sequencer between the SPI slave frame interface and an on-chip byte memory. Each received frame is RX_FRAME_WIDTH bits wide and carries a 2-bit opcode plus an 8-bit payload.
- The block decodes each frame, maintains separate write and read address pointers, and writes the memory.
- For read commands it fetches a byte and presents it on tx_data/tx_valid so the slave can shift it out on MISO.

Parameters:
- FRAME_WIDTH, 8, payload width; also the tx_data width.
- CTRL_WIDTH, 2, opcode width; fixed at 2 (other values unsupported).
- RX_FRAME_WIDTH, FRAME_WIDTH+CTRL_WIDTH, width of rx_data.
- MEM_DEPTH, 256, number of memory words; power of two, at most 2**FRAME_WIDTH.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width; the pointer takes payload[ADDR_WIDTH-1:0].
- TX_HOLD, FRAME_WIDTH+1, number of cycles tx_valid is held high per read.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- rx_valid, input, 1, frame-complete level from the SPI slave; stays high until the slave returns to idle.
- rx_data, input, RX_FRAME_WIDTH, received frame; [9:8] opcode, [7:0] payload.
- tx_valid, output, 1, read byte available to the slave.
- tx_data, output, FRAME_WIDTH, read byte.
- busy, output, 1, high whenever state is not IDLE.
- cmd_err, output, 1, sticky flag: a command was dropped.

Behaviour:
- Reset: synchronous on rst_n=0; clk is the clock.
  - Reset values: tx_valid=0, tx_data=0, busy=0, cmd_err=0, wr_addr=0, rd_addr=0, rx_valid_q=0, state=IDLE.
  - Memory contents are not reset.
  - Reset asserted mid-operation aborts any fetch or hold; tx_valid drops on the next edge.
- Frame detection:
  - rx_valid_q registers rx_valid every cycle.
  - A new frame is the cycle where rx_valid=1 and rx_valid_q=0 (rising edge).
  - A level held high is never re-executed.
- Opcodes, executed on the detect edge, only in IDLE:
  - 00 WR_ADDR: wr_addr <= payload.
  - 01 WR_DATA: mem[wr_addr] <= payload; memory is updated at that edge.
  - 10 RD_ADDR: rd_addr <= payload.
  - 11 RD_DATA: payload is ignored; state goes to FETCH.
- State machine:
  - IDLE -> FETCH on an RD_DATA detect. All other opcodes stay in IDLE.
  - FETCH: one cycle; tx_data <= mem[rd_addr]; go to HOLD and load hold_cnt=TX_HOLD-1.
  - HOLD: tx_valid=1. Decrement hold_cnt each cycle; when hold_cnt==0, tx_valid <= 0 and go to IDLE.
- Latency:
  - Write commands take effect at the detect edge.
  - For RD_DATA, tx_data is valid from the cycle after the FETCH edge; tx_valid is high for exactly TX_HOLD consecutive cycles.
  - The first tx_valid=1 cycle is 2 cycles after the detect cycle.
- tx_data holds its value after tx_valid falls, until the next FETCH.
- Boundary conditions:
  - A detect edge while in FETCH or HOLD: the command is dropped, cmd_err <= 1, and the current read continues unaffected.
  - cmd_err clears only on reset.
  - Address payload bits above ADDR_WIDTH are ignored.
  - An RD_DATA with no preceding RD_ADDR reads mem[rd_addr] using the reset value 0.
  - rx_data is sampled only in the detect cycle; changes at any other time are ignored.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- Defined:
  - After each WR_DATA, wr_addr <= wr_addr+1.
  - After each FETCH, rd_addr <= rd_addr+1.
  - Both wrap modulo MEM_DEPTH (MEM_DEPTH-1 -> 0).
  - An explicit WR_ADDR or RD_ADDR overrides the pointer.
- Not defined: pointers change only on the WR_ADDR and RD_ADDR opcodes.

Test Plan:
- Reset then idle: tx_valid=0, tx_data=0, busy=0, cmd_err=0 for 20 cycles.
- Write then read back:
  - Stimulus: frames 0x012 (WR_ADDR 0x12), 0x1A5 (WR_DATA 0xA5), 0x212 (RD_ADDR 0x12), 0x300 (RD_DATA).
  - Response: tx_data=0xA5; tx_valid high exactly 9 cycles, starting 2 cycles after the RD_DATA rise; busy high for 10 cycles.
- rx_valid held high 15 cycles on 0x1A5: memory written once only. Check by re-writing the address with 0x3C in a separate frame and reading back 0x3C.
- Overlap: a WR_ADDR frame detected during HOLD sets cmd_err=1 and wr_addr is unchanged. The in-flight tx_valid still completes 9 cycles with the correct data.
- Reset mid-HOLD (rst_n=0 at the 4th tx_valid cycle): the next edge gives tx_valid=0, busy=0, rd_addr=0. Previously written memory is still readable after reset.
- With SPI_RAM_AUTOINC_EN:
  - Stimulus: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, RD_ADDR 0xFF, RD_DATA, RD_DATA.
  - Response: reads return 0x11 then 0x22, confirming wrap to address 0. Without the macro, both reads return 0x11.

Source files
------------

// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - frame/handshake bundle between the SPI slave and spi_ram_ctrl
//
// Signals:
//   rx_valid  frame-complete level from the SPI slave
//   rx_data   received frame: [RX-1 -: CTRL_WIDTH] opcode, [FRAME_WIDTH-1:0] payload
//   tx_valid  read byte available to the slave
//   tx_data   read byte
//   busy      controller not idle
//   cmd_err   sticky dropped-command flag
// Modports: master = SPI slave side, slave = spi_ram_ctrl side.
interface spi_ram_ctrl_if #(
    parameter int FRAME_WIDTH = 8,
    parameter int CTRL_WIDTH  = 2
);
    localparam int RX_FRAME_WIDTH = FRAME_WIDTH + CTRL_WIDTH;

    logic                      rx_valid;
    logic [RX_FRAME_WIDTH-1:0] rx_data;
    logic                      tx_valid;
    logic [FRAME_WIDTH-1:0]    tx_data;
    logic                      busy;
    logic                      cmd_err;

    modport master (
        output rx_valid, rx_data,
        input  tx_valid, tx_data, busy, cmd_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output tx_valid, tx_data, busy, cmd_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI frame command sequencer in front of an on-chip byte memory
//
// Decodes each received frame (2-bit opcode + payload) on the rising edge of
// rx_valid, maintains write/read address pointers, writes the memory and
// fetches bytes for the slave to shift out.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    spi_ram_ctrl_if.slave: rx_valid/rx_data in, tx_valid/tx_data/busy/cmd_err out
//
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment wr_addr after
// every WR_DATA and rd_addr after every fetch (wrapping modulo MEM_DEPTH).
module spi_ram_ctrl #(
    parameter int FRAME_WIDTH    = 8,
    parameter int CTRL_WIDTH     = 2,
    parameter int RX_FRAME_WIDTH = FRAME_WIDTH + CTRL_WIDTH,
    parameter int MEM_DEPTH      = 256,
    parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
    parameter int TX_HOLD        = FRAME_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_ram_ctrl_if.slave bus
);

    localparam int HOLD_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_rx_valid_q;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [FRAME_WIDTH-1:0]  r_tx_data;
    logic                    r_tx_valid;
    logic                    r_busy;
    logic                    r_cmd_err;
    logic [FRAME_WIDTH-1:0]  r_mem [MEM_DEPTH];

    logic                    w_detect;
    logic [1:0]              w_opcode;
    logic [FRAME_WIDTH-1:0]  w_payload;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_mem_we;

    // A frame is acted on only at the 0->1 transition of rx_valid, so a level
    // held high by the slave never re-executes.
    assign w_detect  = bus.rx_valid & ~r_rx_valid_q;
    assign w_opcode  = bus.rx_data[RX_FRAME_WIDTH-1 -: 2];
    assign w_payload = bus.rx_data[FRAME_WIDTH-1:0];
    assign w_addr    = w_payload[ADDR_WIDTH-1:0];
    assign w_mem_we  = w_detect && (r_state == S_IDLE) && (w_opcode == OP_WR_DATA);

    // Memory contents survive reset; only writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rx_valid_q <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_hold_cnt   <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_rx_valid_q <= bus.rx_valid;

            case (r_state)
                S_IDLE: begin
                    if (w_detect) begin
                        case (w_opcode)
                            OP_WR_ADDR: r_wr_addr <= w_addr;
                            OP_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
`endif
                            end
                            OP_RD_ADDR: r_rd_addr <= w_addr;
                            OP_RD_DATA: begin
                                r_state <= S_FETCH;
                                r_busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_FETCH: begin
                    r_tx_data  <= r_mem[r_rd_addr];
`ifdef SPI_RAM_AUTOINC_EN
                    r_rd_addr  <= r_rd_addr + ADDR_WIDTH'(1);
`endif
                    r_hold_cnt <= HOLD_W'(TX_HOLD - 1);
                    r_tx_valid <= 1'b1;
                    r_state    <= S_HOLD;
                end

                S_HOLD: begin
                    // hold_cnt runs TX_HOLD-1 .. 0, giving TX_HOLD cycles of tx_valid.
                    if (r_hold_cnt == '0) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end

                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase

            // A frame arriving while a read is in flight is dropped, not queued.
            if (w_detect && (r_state != S_IDLE)) begin
                r_cmd_err <= 1'b1;
            end
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.busy     = r_busy;
    assign bus.cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - randomized self-checking bench for spi_ram_ctrl
module tb_spi_ram_ctrl;

    localparam int FW        = 8;
    localparam int CW        = 2;
    localparam int MEM_DEPTH = 256;
    localparam int TX_HOLD   = FW + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl_if #(.FRAME_WIDTH(FW), .CTRL_WIDTH(CW)) u_if ();

    spi_ram_ctrl #(
        .FRAME_WIDTH(FW),
        .CTRL_WIDTH (CW),
        .MEM_DEPTH  (MEM_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (u_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory image, pointers and sticky error flag.
    logic [7:0] m_mem [MEM_DEPTH];
    logic [7:0] m_wr;
    logic [7:0] m_rd;
    logic       m_err;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue a non-read frame with rx_valid held for `hold` cycles; rx_data is
    // scrambled after the first cycle since only the detect cycle matters.
    task automatic send_frame(input logic [9:0] frame, input int hold);
        u_if.rx_data  = frame;
        u_if.rx_valid = 1'b1;
        case (frame[9:8])
            2'b00: m_wr = frame[7:0];
            2'b01: begin
                m_mem[m_wr] = frame[7:0];
`ifdef SPI_RAM_AUTOINC_EN
                m_wr = m_wr + 8'd1;
`endif
            end
            2'b10: m_rd = frame[7:0];
            default: ;
        endcase
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            u_if.rx_data = 10'($urandom);
        end
        u_if.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    // RD_DATA transaction observed over a fixed 14-cycle window.
    // mode 0: plain read; mode 1: inject `inj` during HOLD; mode 2: reset at 4th tx_valid cycle.
    task automatic do_read(input int mode, input logic [9:0] inj);
        logic [7:0] exp_data;
        int         first;
        int         n_tv;
        int         n_busy;
        logic [7:0] d_first;
        logic       data_ok;
        first   = -1;
        n_tv    = 0;
        n_busy  = 0;
        d_first = 8'h00;
        data_ok = 1'b1;
        exp_data = m_mem[m_rd];
`ifdef SPI_RAM_AUTOINC_EN
        m_rd = m_rd + 8'd1;
`endif
        u_if.rx_data  = 10'h300 | 10'($urandom_range(0, 255));
        u_if.rx_valid = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) u_if.rx_valid = 1'b0;
            if (mode == 2 && i == 6) begin
                check_eq("rst_tx_valid", u_if.tx_valid, 0);
                check_eq("rst_busy",     u_if.busy,     0);
                check_eq("rst_tx_data",  u_if.tx_data,  0);
                check_eq("rst_cmd_err",  u_if.cmd_err,  0);
                rst_n = 1'b1;
            end
            if (u_if.tx_valid) begin
                if (first < 0) begin
                    first   = i;
                    d_first = u_if.tx_data;
                end
                if (u_if.tx_data !== exp_data) data_ok = 1'b0;
                n_tv++;
            end
            if (u_if.busy) n_busy++;
            if (mode == 1 && i == 4) begin
                u_if.rx_data  = inj;
                u_if.rx_valid = 1'b1;
                m_err = 1'b1;
            end
            if (mode == 1 && i == 5) u_if.rx_valid = 1'b0;
            if (mode == 2 && i == 5) begin
                rst_n = 1'b0;
                m_wr  = 8'h00;
                m_rd  = 8'h00;
                m_err = 1'b0;
            end
        end
        if (mode == 2) begin
            check_eq("rst_tv_cycles", n_tv, 4);
        end else begin
            check_eq("rd_first_tv", first, 2);
            check_eq("rd_tv_cycles", n_tv, TX_HOLD);
            check_eq("rd_busy_cycles", n_busy, TX_HOLD + 1);
            check_eq("rd_data", d_first, exp_data);
            check_eq("rd_data_steady", data_ok, 1);
            check_eq("rd_data_after", u_if.tx_data, exp_data);
            check_eq("rd_cmd_err", u_if.cmd_err, m_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = '0;
        m_wr  = 8'h00;
        m_rd  = 8'h00;
        m_err = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_tx_valid", u_if.tx_valid, 0);
            check_eq("idle_tx_data",  u_if.tx_data,  0);
            check_eq("idle_busy",     u_if.busy,     0);
            check_eq("idle_cmd_err",  u_if.cmd_err,  0);
        end

        // Give every memory word a known value.
        for (int a = 0; a < MEM_DEPTH; a++) begin
            send_frame({2'b00, 8'(a)}, 1);
            send_frame({2'b01, 8'($urandom)}, 1);
        end

        // Write then read back.
        send_frame(10'h012, 1);
        send_frame(10'h1A5, 1);
        send_frame(10'h212, 1);
        do_read(0, '0);

        // Held rx_valid must execute once only.
        send_frame(10'h012, 1);
        send_frame(10'h1A5, 15);
        send_frame(10'h212, 1);
        do_read(0, '0);
        send_frame(10'h012, 1);
        send_frame(10'h13C, 1);
        send_frame(10'h212, 1);
        do_read(0, '0);

        // Overlap: WR_ADDR during HOLD is dropped and flags cmd_err.
        send_frame(10'h020, 1);
        send_frame(10'h212, 1);
        do_read(1, 10'h055);
        send_frame(10'h1C7, 1);
        send_frame(10'h220, 1);
        do_read(0, '0);
        send_frame(10'h255, 1);
        do_read(0, '0);

        // Reset mid-HOLD, then memory still readable from rd_addr 0.
        send_frame(10'h212, 1);
        do_read(2, '0);
        do_read(0, '0);

        // Randomized command mix.
        for (int k = 0; k < 60; k++) begin
            int op;
            op = int'($urandom_range(0, 3));
            if (op == 3) do_read(0, '0);
            else send_frame({2'(op), 8'($urandom)}, int'($urandom_range(1, 4)));
        end

        // Pointer wrap scenario.
        send_frame(10'h0FF, 1);
        send_frame(10'h111, 1);
        send_frame(10'h122, 1);
        send_frame(10'h2FF, 1);
        do_read(0, '0);
        do_read(0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
